mistral_mul54_seq: RTL
======================

Name: mistral_mul54_seq

Overview:
- Multi-cycle 54x54 multiplier sequencer built on one shared 27x27 hard multiplier, instantiated as MISTRAL_MUL27X27 with A_SIGNED=0 and B_SIGNED=0.
- Splits each operand into 27-bit halves, issues four partial products and accumulates them into a 108-bit result.
- Valid/ready handshake on the input and output sides.
- Used by the DSP mapping flow when a product wider than 27x27 must fit into a single DSP block and throughput can be traded for area.

Parameters:
- REG_PP, 0, when 1 the 27x27 partial product is registered before accumulation: +1 cycle latency, shorter critical path.

Ports:
- CLK  input  1  clock, rising edge.
- ACLR  input  1  asynchronous active-low reset; clears all state.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- in_a  input  54  multiplicand.
- in_b  input  54  multiplier.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_p  output  108  product.
- busy  output  1  high in any state except IDLE.

Behaviour:
- States: IDLE, MUL, DRAIN (REG_PP=1 only), CORR (MUL54_SIGNED_EN only), DONE.
- Reset (ACLR low, async):
  - state=IDLE, step=0, acc=0, out_p=0, out_valid=0, busy=0.
  - in_ready=1 combinationally, but no transfer can occur while ACLR is low.
  - Reset mid-operation aborts the operation with no output.
- in_ready = (state==IDLE). Accept happens on the edge where in_valid & in_ready; that edge latches in_a/in_b into op regs, clears acc, sets step=0 and goes to MUL.
- Operand halves: AL=a[26:0], AH=a[53:27], BL=b[26:0], BH=b[53:27].
- Step order and accumulation shift:
  - step0: AL*BL, shift 0.
  - step1: AL*BH, shift 27.
  - step2: AH*BL, shift 27.
  - step3: AH*BH, shift 54.
- Accumulation is 108-bit unsigned, modulo 2^108.
- Multiplier inputs are muxed by step. A/B are driven only in MUL; they are held at 0 otherwise to avoid toggling.
- REG_PP=0:
  - Each MUL cycle adds the shifted product into acc at the edge.
  - After step3: to CORR if signed mode is compiled in and the latched sign flag is set, else to DONE.
  - Latency from accept edge to out_valid=1: 4 cycles.
- REG_PP=1:
  - Product register pp (54b) and a pp_valid/shift tag are captured each MUL cycle; acc adds pp one cycle later.
  - After step3 capture, go to DRAIN (final add), then CORR/DONE.
  - Latency: 5 cycles.
- DONE:
  - out_valid=1; out_p=acc, held stable until out_ready.
  - On the edge with out_valid & out_ready, go to IDLE; out_valid drops next cycle.
  - out_p keeps its last value in IDLE.
- No input acceptance while busy or in DONE; back-to-back throughput is one operation per 5 cycles (REG_PP=0).
- out_ready high before DONE has no effect.
- in_valid and in_a/in_b are ignored outside IDLE.

Optional Feature:
- Macro: MUL54_SIGNED_EN.
- Defined:
  - Adds input port in_signed (1b), latched at accept.
  - When the latched flag is set, the CORR state (1 cycle) after accumulation computes acc = acc - ((a[53] ? b : 0) << 54) - ((b[53] ? a : 0) << 54), modulo 2^108. This yields the two's-complement 108-bit product.
  - Signed ops take +1 cycle; unsigned ops skip CORR.
- Undefined:
  - No in_signed port, no CORR state; all operands are treated as unsigned.

Test Plan:
- Basic unsigned, REG_PP=0: a=3, b=5 accepted at edge E -> out_valid at E+4, out_p=15, busy high E..E+4.
- Cross term: a=2^27, b=2^27 -> out_p=2^54; a=2^54-1, b=2^54-1 -> out_p=2^108-2^55+1.
- Backpressure: out_ready low for 10 cycles after out_valid -> out_p stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE next cycle; the next op is accepted and correct.
- Reset mid-op: ACLR pulsed low during step2 -> out_valid=0, acc=0, in_ready=1 immediately; next op a=7, b=9 -> 63 with normal latency.
- REG_PP=1: a=2^53+1, b=2 -> out_p=2^54+2, out_valid at E+5.
- MUL54_SIGNED_EN:
  - a=-1, b=-1, in_signed=1 -> out_p=1, latency 5.
  - a=-2^53, b=1 -> out_p = -2^53 sign-extended to 108b.
  - Same operands with in_signed=0 -> unsigned product, latency 4.

Source files
------------

// File: rtl/mistral_mul54_seq_if.sv
//------------------------------------------------------------------------------
//  Module   : mistral_mul54_seq_if
//  Purpose  : Handshake/data bundle for the 54x54 sequential multiplier.
//             master = operand producer / result consumer
//             slave  = multiplier sequencer
//  Signals  : in_valid/in_ready/in_a/in_b   operand channel
//             in_signed                     signed-operation flag
//                                           (only with MUL54_SIGNED_EN)
//             out_valid/out_ready/out_p     result channel
//             busy                          sequencer not idle
//  Config   : MUL54_SIGNED_EN adds the in_signed signal.
//  Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mistral_mul54_seq_if;
   logic          in_valid;
   logic          in_ready;
   logic [53:0]   in_a;
   logic [53:0]   in_b;
`ifdef MUL54_SIGNED_EN
   logic          in_signed;
`endif
   logic          out_valid;
   logic          out_ready;
   logic [107:0]  out_p;
   logic          busy;

   modport master (
`ifdef MUL54_SIGNED_EN
      output in_signed,
`endif
      output in_valid,
      output in_a,
      output in_b,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_p,
      input  busy
   );

   modport slave (
`ifdef MUL54_SIGNED_EN
      input  in_signed,
`endif
      input  in_valid,
      input  in_a,
      input  in_b,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_p,
      output busy
   );
endinterface

`default_nettype wire

// File: rtl/mistral_mul54_seq.sv
//------------------------------------------------------------------------------
//  Module   : mistral_mul54_seq
//  Purpose  : 54x54 -> 108-bit multiplier built from one shared 27x27 hard
//             multiplier. Each operand is split into 27-bit halves and the
//             four partial products are accumulated over four MUL cycles.
//  Ports    : CLK        clock, rising edge
//             ACLR       asynchronous active-low clear of all state
//             bus        mistral_mul54_seq_if.slave (valid/ready operand and
//                        result channels, busy indicator)
//  Params   : REG_PP     1 = register the partial product before the add
//                        (+1 cycle latency, shorter path)
//  Config   : `define MUL54_SIGNED_EN to add the in_signed flag and the
//             two's-complement correction state (CORR).
//  Latency  : accept edge -> out_valid: 4 (REG_PP=0) / 5 (REG_PP=1),
//             +1 for signed operations.
//  Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mistral_mul54_seq #(
   parameter int REG_PP = 0
) (
   input  logic                     CLK,
   input  logic                     ACLR,
   mistral_mul54_seq_if.slave       bus
);

   localparam logic c_reg_pp = (REG_PP != 0);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MUL   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_CORR  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t         r_state;
   state_t         w_state_next;
   logic [1:0]     r_step;
   logic [1:0]     w_step_next;
   logic [53:0]    r_a;
   logic [53:0]    r_b;
   logic [107:0]   r_acc;
   logic [107:0]   w_acc_next;
   logic [107:0]   r_out_p;

   logic [26:0]    w_mul_a;
   logic [26:0]    w_mul_b;
   logic [53:0]    w_mul_y;

   logic           w_accept;
   logic           w_add_en;
   logic [107:0]   w_add_val;
   logic           w_go_corr;
   logic [107:0]   w_corr_val;
   state_t         w_post_acc;

   // Place a 54-bit partial product at its weight for the given step:
   // step0 -> 0, steps 1/2 (cross terms) -> 27, step3 -> 54.
   function automatic logic [107:0] f_shift(input logic [53:0] p,
                                            input logic [1:0]  s);
      logic [107:0] v;
      v = {54'b0, p};
      case (s)
         2'd0:    f_shift = v;
         2'd3:    f_shift = v << 54;
         default: f_shift = v << 27;
      endcase
   endfunction

   //---------------------------------------------------------------------------
   // Handshake
   //---------------------------------------------------------------------------
   assign w_accept      = bus.in_valid && (r_state == ST_IDLE);
   assign bus.in_ready  = (r_state == ST_IDLE);
   assign bus.out_valid = (r_state == ST_DONE);
   assign bus.out_p     = r_out_p;
   assign bus.busy      = (r_state != ST_IDLE);

   //---------------------------------------------------------------------------
   // Shared multiplier. Inputs are forced to zero outside MUL so the hard
   // block does not toggle while idle. step[1] picks the a half, step[0]
   // the b half, giving AL*BL, AL*BH, AH*BL, AH*BH.
   //---------------------------------------------------------------------------
   assign w_mul_a = (r_state != ST_MUL) ? 27'd0 :
                    (r_step[1] ? r_a[53:27] : r_a[26:0]);
   assign w_mul_b = (r_state != ST_MUL) ? 27'd0 :
                    (r_step[0] ? r_b[53:27] : r_b[26:0]);

   MISTRAL_MUL27X27 #(
      .A_SIGNED (0),
      .B_SIGNED (0)
   ) u_mul (
      .A (w_mul_a),
      .B (w_mul_b),
      .Y (w_mul_y)
   );

   //---------------------------------------------------------------------------
   // Partial-product path: either straight into the adder, or through a
   // pipeline register carrying its own weight tag so the add can trail the
   // multiply by one cycle.
   //---------------------------------------------------------------------------
   generate
      if (REG_PP != 0) begin : g_pp_reg
         logic [53:0] r_pp;
         logic [1:0]  r_pp_tag;
         logic        r_pp_valid;

         always_ff @(posedge CLK or negedge ACLR) begin
            if (!ACLR) begin
               r_pp       <= '0;
               r_pp_tag   <= '0;
               r_pp_valid <= 1'b0;
            end else begin
               r_pp_valid <= (r_state == ST_MUL);
               if (r_state == ST_MUL) begin
                  r_pp     <= w_mul_y;
                  r_pp_tag <= r_step;
               end
            end
         end

         assign w_add_en  = r_pp_valid;
         assign w_add_val = f_shift(r_pp, r_pp_tag);
      end else begin : g_pp_comb
         assign w_add_en  = (r_state == ST_MUL);
         assign w_add_val = f_shift(w_mul_y, r_step);
      end
   endgenerate

   //---------------------------------------------------------------------------
   // Signed correction. Reading both operands as unsigned overcounts by
   // a53*b*2^54 + b53*a*2^54 (the a53*b53*2^108 term wraps away), so
   // subtracting those two terms yields the two's-complement product.
   //---------------------------------------------------------------------------
`ifdef MUL54_SIGNED_EN
   logic r_signed;

   always_ff @(posedge CLK or negedge ACLR) begin
      if (!ACLR) begin
         r_signed <= 1'b0;
      end else if (w_accept) begin
         r_signed <= bus.in_signed;
      end
   end

   assign w_go_corr  = r_signed;
   assign w_corr_val = (r_a[53] ? {r_b, 54'b0} : 108'd0) +
                       (r_b[53] ? {r_a, 54'b0} : 108'd0);
`else
   assign w_go_corr  = 1'b0;
   assign w_corr_val = '0;
`endif

   assign w_post_acc = w_go_corr ? ST_CORR : ST_DONE;

   //---------------------------------------------------------------------------
   // FSM: next state and accumulator
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_step_next  = r_step;
      w_acc_next   = r_acc;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_next = ST_MUL;
               w_step_next  = 2'd0;
               w_acc_next   = '0;
            end
         end

         ST_MUL: begin
            if (w_add_en) begin
               w_acc_next = r_acc + w_add_val;
            end
            w_step_next = r_step + 2'd1;
            if (r_step == 2'd3) begin
               // With a registered product the last term is still in the
               // pipeline register and needs one more cycle to land.
               w_state_next = c_reg_pp ? ST_DRAIN : w_post_acc;
            end
         end

         ST_DRAIN: begin
            if (w_add_en) begin
               w_acc_next = r_acc + w_add_val;
            end
            w_state_next = w_post_acc;
         end

         ST_CORR: begin
            w_acc_next   = r_acc - w_corr_val;
            w_state_next = ST_DONE;
         end

         ST_DONE: begin
            if (bus.out_ready) begin
               w_state_next = ST_IDLE;
            end
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // FSM: state register. The result register is loaded on the edge that
   // enters DONE so it survives the accumulator clear of the next accept.
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge ACLR) begin
      if (!ACLR) begin
         r_state <= ST_IDLE;
         r_step  <= 2'd0;
         r_acc   <= '0;
         r_out_p <= '0;
         r_a     <= '0;
         r_b     <= '0;
      end else begin
         r_state <= w_state_next;
         r_step  <= w_step_next;
         r_acc   <= w_acc_next;
         if (w_accept) begin
            r_a <= bus.in_a;
            r_b <= bus.in_b;
         end
         if ((w_state_next == ST_DONE) && (r_state != ST_DONE)) begin
            r_out_p <= w_acc_next;
         end
      end
   end

endmodule

//------------------------------------------------------------------------------
//  Module   : MISTRAL_MUL27X27
//  Purpose  : Behavioural model of the 27x27 hard multiplier. Y is the low
//             54 bits of A*B, each operand sign- or zero-extended according
//             to A_SIGNED / B_SIGNED. When mapping onto the device the
//             library cell takes the place of this model.
//  Ports    : A[26:0], B[26:0] operands; Y[53:0] product
//  Revision : 1.0  initial release
//------------------------------------------------------------------------------
module MISTRAL_MUL27X27 #(
   parameter int A_SIGNED = 1,
   parameter int B_SIGNED = 1
) (
   input  logic [26:0] A,
   input  logic [26:0] B,
   output logic [53:0] Y
);

   logic [53:0] w_a_ext;
   logic [53:0] w_b_ext;

   assign w_a_ext = (A_SIGNED != 0) ? {{27{A[26]}}, A} : {27'b0, A};
   assign w_b_ext = (B_SIGNED != 0) ? {{27{B[26]}}, B} : {27'b0, B};
   assign Y       = w_a_ext * w_b_ext;

endmodule

`default_nettype wire
